// File: rtl/md_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: FSM encoding,
// funct3 opcodes and operand-signedness helpers.
package md_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdState_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic a_signed(input logic [2:0] f3);
    logic s;
    case (f3)
      F3_MULH, F3_MULHSU, F3_DIV, F3_REM:    s = 1'b1;
      F3_MUL, F3_MULHU, F3_DIVU, F3_REMU:    s = 1'b0;
      default:                               s = 1'b0;
    endcase
    return s;
  endfunction

  function automatic logic b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/md_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits, using one subtractor.
module md_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic            fits;
  logic [1:0]      unusedBits;

  assign shifted = {rem_in, quo_in[XLEN-1]};
  assign diff    = {1'b0, shifted} - {2'b00, divisor};
  // The borrow out of the subtractor doubles as the compare result.
  assign fits    = ~diff[XLEN+1];

  // rem_in < divisor keeps the shifted value below 2*divisor, so the top bits
  // are zero whenever they would be selected.
  assign rem_out    = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_out    = {quo_in[XLEN-2:0], fits};
  assign unusedBits = {diff[XLEN], shifted[XLEN]};

endmodule

// File: rtl/muldiv_sequencer.sv
// Execute-stage RV32M sequencer: iterative shift-add multiply and restoring
// divide. Define FAST_MUL_EN for a single-cycle combinational multiply path.
module muldiv_sequencer
  import md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StartE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic            BusyE,
  output logic            DoneE,
  output logic [XLEN-1:0] ResultMD
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  mdState_t        state, stateNext;
  logic [CW-1:0]   count;
  logic [2:0]      f3Q;
  logic            signAQ, signBQ;
  logic [XLEN-1:0] operandQ;
  logic [XLEN-1:0] accHi, accLo;

  logic            accept, startIsDiv, negA, negB, divZero, divOvf;
  logic [XLEN-1:0] absA, absB, specialResult, startResult;
  logic            startToDone;

  assign accept     = (state == IDLE) && StartE && !FlushE;
  assign startIsDiv = is_div(Funct3E);
  assign negA       = a_signed(Funct3E) && SrcAE[XLEN-1];
  assign negB       = b_signed(Funct3E) && SrcBE[XLEN-1];
  assign absA       = negA ? -SrcAE : SrcAE;
  assign absB       = negB ? -SrcBE : SrcBE;
  assign divZero    = startIsDiv && (SrcBE == '0);
  assign divOvf     = startIsDiv && !Funct3E[0] && (SrcAE == MIN_NEG) && (SrcBE == '1);

  always_comb begin
    specialResult = '0;
    if (divZero)
      specialResult = Funct3E[1] ? SrcAE : '1;
    else if (divOvf)
      specialResult = Funct3E[1] ? '0 : SrcAE;
  end

`ifdef FAST_MUL_EN
  logic [2*XLEN-1:0] fastA, fastB, fastProd;
  logic [XLEN-1:0]   fastResult;

  assign fastA       = {{XLEN{negA}}, SrcAE};
  assign fastB       = {{XLEN{negB}}, SrcBE};
  assign fastProd    = fastA * fastB;
  assign fastResult  = (Funct3E == F3_MUL) ? fastProd[XLEN-1:0] : fastProd[2*XLEN-1:XLEN];
  assign startToDone = divZero || divOvf || !startIsDiv;
  assign startResult = startIsDiv ? specialResult : fastResult;
`else
  assign startToDone = divZero || divOvf;
  assign startResult = specialResult;
`endif

  // accHi/accLo hold product high/low halves for multiply, and
  // remainder/quotient-with-pending-dividend-bits for divide.
  logic [XLEN:0]     mulSum;
  logic [XLEN-1:0]   divRem, divQuo, stepHi, stepLo;
  logic [2*XLEN-1:0] prod, prodSigned;
  logic [XLEN-1:0]   mulResult, quoSigned, remSigned, finalResult;

  md_div_step #(.XLEN(XLEN)) uDivStep (
    .rem_in  (accHi),
    .quo_in  (accLo),
    .divisor (operandQ),
    .rem_out (divRem),
    .quo_out (divQuo)
  );

  assign mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, operandQ} : '0);

  always_comb begin
    stepHi = mulSum[XLEN:1];
    stepLo = {mulSum[0], accLo[XLEN-1:1]};
    if (is_div(f3Q)) begin
      stepHi = divRem;
      stepLo = divQuo;
    end
  end

  assign prod        = {stepHi, stepLo};
  assign prodSigned  = (signAQ ^ signBQ) ? -prod : prod;
  assign mulResult   = (f3Q == F3_MUL) ? prodSigned[XLEN-1:0] : prodSigned[2*XLEN-1:XLEN];
  assign quoSigned   = (signAQ ^ signBQ) ? -stepLo : stepLo;
  assign remSigned   = signAQ ? -stepHi : stepHi;
  assign finalResult = is_div(f3Q) ? (f3Q[1] ? remSigned : quoSigned) : mulResult;

  always_comb begin
    stateNext = state;
    BusyE     = 1'b0;
    DoneE     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          BusyE     = 1'b1;
          stateNext = startToDone ? DONE : RUN;
        end
      end
      RUN: begin
        BusyE = 1'b1;
        if (FlushE)
          stateNext = IDLE;
        else if (count == '0)
          stateNext = DONE;
      end
      DONE: begin
        // StartE is not looked at here; the finished op retires first.
        DoneE     = !FlushE;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      ResultMD <= '0;
      f3Q      <= '0;
      signAQ   <= 1'b0;
      signBQ   <= 1'b0;
      operandQ <= '0;
      accHi    <= '0;
      accLo    <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (accept) begin
            f3Q      <= Funct3E;
            signAQ   <= negA;
            signBQ   <= negB;
            count    <= CNT_LAST;
            accHi    <= '0;
            accLo    <= startIsDiv ? absA : absB;
            operandQ <= startIsDiv ? absB : absA;
            if (startToDone)
              ResultMD <= startResult;
          end
        end
        RUN: begin
          if (!FlushE) begin
            accHi <= stepHi;
            accLo <= stepLo;
            if (count == '0)
              ResultMD <= finalResult;
            else
              count <= count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (XLEN=32); expected
// latencies follow FAST_MUL_EN when the bench is built with it.
module tb_muldiv_sequencer;

  localparam int XLEN    = 32;
`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            StartE;
  logic [2:0]      Funct3E;
  logic [XLEN-1:0] SrcAE, SrcBE;
  logic            FlushE;
  logic            BusyE, DoneE;
  logic [XLEN-1:0] ResultMD;

  int              checks   = 0;
  int              failures = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] last_res;

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .reset    (reset),
    .StartE   (StartE),
    .Funct3E  (Funct3E),
    .SrcAE    (SrcAE),
    .SrcBE    (SrcBE),
    .FlushE   (FlushE),
    .BusyE    (BusyE),
    .DoneE    (DoneE),
    .ResultMD (ResultMD)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // driver: issue one op, then follow it to DoneE and score the result
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res, input int exp_lat);
    int              cyc;
    int              busy_cnt;
    logic [XLEN-1:0] want;
    exp_q.push_back(exp_res);
    StartE  = 1'b1;
    Funct3E = f3;
    SrcAE   = a;
    SrcBE   = b;
    #1;
    check({tag, "_busy_T"}, XLEN'(BusyE), XLEN'(1));
    tick();
    StartE   = 1'b0;
    SrcAE    = $urandom();
    SrcBE    = $urandom();
    Funct3E  = 3'($urandom_range(0, 7));
    busy_cnt = 1;
    cyc      = 1;
    while (DoneE !== 1'b1 && cyc < 200) begin
      if (BusyE === 1'b1) busy_cnt++;
      tick();
      cyc++;
    end
    want = exp_q.pop_front();
    check({tag, "_latency"}, XLEN'(cyc), XLEN'(exp_lat));
    check({tag, "_busy_cycles"}, XLEN'(busy_cnt), XLEN'(exp_lat));
    check({tag, "_busy_in_done"}, XLEN'(BusyE), XLEN'(0));
    check({tag, "_result"}, ResultMD, want);
    tick();
    check({tag, "_done_pulse"}, XLEN'(DoneE), XLEN'(0));
    check({tag, "_result_held"}, ResultMD, want);
    last_res = want;
  endtask

  initial begin
    int done_seen;
    reset   = 1'b0;
    StartE  = 1'b0;
    FlushE  = 1'b0;
    Funct3E = 3'b000;
    SrcAE   = '0;
    SrcBE   = '0;
    repeat (3) tick();
    check("reset_busy", XLEN'(BusyE), XLEN'(0));
    check("reset_done", XLEN'(DoneE), XLEN'(0));
    check("reset_result", ResultMD, 32'h0000_0000);
    reset = 1'b1;
    tick();

    // multiply
    run_op("mul_7_m3",      3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run_op("mul_big",       3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, MUL_LAT);
    run_op("mulhu_ones",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mulh_ones",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
    run_op("mulhsu_ones",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
    run_op("mulh_m2_3",     3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, MUL_LAT);
    run_op("mulhu_big",     3'b011, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, MUL_LAT);

    // divide
    run_op("div_m7_2",      3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT);
    run_op("rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT);
    run_op("divu_100_7",    3'b101, 32'd100,       32'd7,         32'd14,        DIV_LAT);
    run_op("remu_100_7",    3'b111, 32'd100,       32'd7,         32'd2,         DIV_LAT);
    run_op("div_7_m2",      3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
    run_op("rem_7_m2",      3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, DIV_LAT);
    run_op("divu_max_1",    3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, DIV_LAT);

    // special cases finish one cycle after acceptance
    run_op("divu_by_zero",  3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem_by_zero",   3'b110, 32'd5,         32'd0,         32'd5,         1);
    run_op("div_by_zero",   3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("div_overflow",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_overflow",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

    // flush mid-divide at T+10
    StartE  = 1'b1;
    Funct3E = 3'b101;
    SrcAE   = 32'd1000;
    SrcBE   = 32'd3;
    tick();
    StartE = 1'b0;
    repeat (9) tick();
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0;
    check("flush_busy", XLEN'(BusyE), XLEN'(0));
    check("flush_done", XLEN'(DoneE), XLEN'(0));
    check("flush_result", ResultMD, last_res);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (DoneE === 1'b1) done_seen++;
      tick();
    end
    check("flush_no_done", XLEN'(done_seen), XLEN'(0));
    check("flush_result_later", ResultMD, last_res);
    run_op("after_flush",   3'b111, 32'd100,       32'd7,         32'd2,         DIV_LAT);

    // reset mid-multiply at T+5
    StartE  = 1'b1;
    Funct3E = 3'b000;
    SrcAE   = 32'h0000_0007;
    SrcBE   = 32'hFFFF_FFFD;
    tick();
    StartE = 1'b0;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    check("midreset_busy", XLEN'(BusyE), XLEN'(0));
    check("midreset_done", XLEN'(DoneE), XLEN'(0));
    check("midreset_result", ResultMD, 32'h0000_0000);
    reset = 1'b1;
    tick();
    run_op("after_reset",   3'b101, 32'd100,       32'd7,         32'd14,        DIV_LAT);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
